// File: rtl/sd_phy_pkg.sv
// Shared types and constants for the SD command-line PHY.
package sd_phy_pkg;

  localparam int FRAME_LEN   = 48;
  localparam int PAYLOAD_LEN = 40;
  localparam logic [6:0] CRC7_POLY = 7'h09;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    SEND      = 3'd1,
    TURN      = 3'd2,
    WAIT_RESP = 3'd3,
    RECV      = 3'd4,
    DONE      = 3'd5
  } state_t;

  // One MSB-first step of CRC7 (x^7 + x^3 + 1).
  function automatic logic [6:0] crc7_step(input logic [6:0] crc, input logic b);
    logic fb;
    fb = b ^ crc[6];
    return {crc[5:0], 1'b0} ^ (fb ? CRC7_POLY : 7'h00);
  endfunction

endpackage

// File: rtl/sd_cmd_phy_if.sv
// Controller/pin bundle for the SD command PHY.
interface sd_cmd_phy_if;
  import sd_phy_pkg::*;

  logic                   strobe_in;
  logic [PAYLOAD_LEN-1:0] cmd_in;
  logic                   ack_in;
  logic                   ack_out;
  logic                   strobe_out;
  logic [PAYLOAD_LEN-1:0] cmd_out;
  logic                   crc_error;
  logic                   resp_timeout;
  logic                   busy;
  logic                   cmd_pin_out;
  logic                   cmd_pin_oe;
  logic                   cmd_pin_in;

  // Controller side (and the card-side pin driver in a bench).
  modport master (
    output strobe_in, cmd_in, ack_in, cmd_pin_in,
    input  ack_out, strobe_out, cmd_out, crc_error, resp_timeout, busy,
           cmd_pin_out, cmd_pin_oe
  );

  // PHY side.
  modport slave (
    input  strobe_in, cmd_in, ack_in, cmd_pin_in,
    output ack_out, strobe_out, cmd_out, crc_error, resp_timeout, busy,
           cmd_pin_out, cmd_pin_oe
  );
endinterface

// File: rtl/sd_cmd_phy_crc7.sv
// Serial CRC7 accumulator shared by transmit and receive paths.
// Clear together with enable restarts the CRC from zero with i_bit as its first bit.
module sd_crc7
  import sd_phy_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic       i_clear,
  input  logic       i_enable,
  input  logic       i_bit,
  output logic [6:0] o_crc
);

  logic [6:0] r_crc;
  logic [6:0] w_base;

  assign w_base = i_clear ? 7'h00 : r_crc;
  assign o_crc  = r_crc;

  // Advance or clear the remainder.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_crc <= 7'h00;
    end else if (i_enable) begin
      r_crc <= crc7_step(w_base, i_bit);
    end else if (i_clear) begin
      r_crc <= 7'h00;
    end
  end

endmodule

// File: rtl/sd_cmd_phy.sv
// SD CMD-line PHY: sends a 48-bit command frame with CRC7, then receives and
// checks the 48-bit response.
//
// state     | meaning
// ----------+------------------------------------------------
// IDLE      | pin released, waiting for an armed strobe_in
// SEND      | driving frame bit r_cnt (47..0) on the pin
// TURN      | pin released for TURN_CYCLES turnaround cycles
// WAIT_RESP | looking for the response start bit
// RECV      | shifting in response bit r_cnt (46..0)
// DONE      | status valid, holding until ack_in
module sd_cmd_phy
  import sd_phy_pkg::*;
#(
  parameter int WAIT_MAX    = 64,
  parameter int TURN_CYCLES = 2
)
(
  input logic         clock,
  input logic         reset,
  sd_cmd_phy_if.slave bus
);

  localparam int WW = $clog2(WAIT_MAX) + 1;

  state_t                 r_state;
  logic [5:0]             r_cnt;
  logic [WW-1:0]          r_wait;
  logic [FRAME_LEN-2:0]   r_shift;
  logic                   r_armed;
  logic                   r_rx_bad;
  logic                   r_ack_out;
  logic                   r_strobe_out;
  logic                   r_crc_error;
  logic                   r_resp_timeout;
  logic                   r_busy;
  logic                   r_pin_out;
  logic                   r_pin_oe;
  logic [PAYLOAD_LEN-1:0] r_cmd_out;

  logic       w_accept;
  logic       w_crc_clear;
  logic       w_crc_en;
  logic       w_crc_bit;
  logic [6:0] w_crc;
  logic [7:0] w_tail;
  logic [2:0] w_idx;

  assign w_accept = (r_state == IDLE) && bus.strobe_in && r_armed;
  // CRC remainder followed by the end bit; w_idx maps frame bit r_cnt-1 into it.
  assign w_tail   = {w_crc, 1'b1};
  assign w_idx    = r_cnt[2:0] - 3'd1;

  sd_crc7 u_crc (
    .clock    (clock),
    .reset    (reset),
    .i_clear  (w_crc_clear),
    .i_enable (w_crc_en),
    .i_bit    (w_crc_bit),
    .o_crc    (w_crc)
  );

  // CRC feed: on transmit the bit is folded in as it is loaded onto the pin,
  // so the remainder is final by the time bit 7 has to be driven.
  always_comb begin
    w_crc_clear = 1'b0;
    w_crc_en    = 1'b0;
    w_crc_bit   = 1'b0;
    case (r_state)
      IDLE: if (w_accept) begin
        w_crc_clear = 1'b1;
        w_crc_en    = 1'b1;
        w_crc_bit   = bus.cmd_in[PAYLOAD_LEN-1];
      end
      SEND: if (r_cnt > 6'd8) begin
        w_crc_en  = 1'b1;
        w_crc_bit = r_shift[FRAME_LEN-2];
      end
      WAIT_RESP: if (!bus.cmd_pin_in) begin
        w_crc_clear = 1'b1;
        w_crc_en    = 1'b1;
        w_crc_bit   = 1'b0;
      end
      RECV: if (r_cnt >= 6'd8) begin
        w_crc_en  = 1'b1;
        w_crc_bit = bus.cmd_pin_in;
      end
      default: ;
    endcase
  end

  // Main sequencer with registered outputs.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state        <= IDLE;
      r_cnt          <= 6'd0;
      r_wait         <= '0;
      r_shift        <= '0;
      r_armed        <= 1'b1;
      r_rx_bad       <= 1'b0;
      r_ack_out      <= 1'b0;
      r_strobe_out   <= 1'b0;
      r_crc_error    <= 1'b0;
      r_resp_timeout <= 1'b0;
      r_busy         <= 1'b0;
      r_pin_out      <= 1'b1;
      r_pin_oe       <= 1'b0;
      r_cmd_out      <= '0;
    end else begin
      r_ack_out <= 1'b0;
      if (!bus.strobe_in) begin
        r_armed <= 1'b1;
      end else if (w_accept) begin
        r_armed <= 1'b0;
      end

      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_shift   <= {bus.cmd_in[PAYLOAD_LEN-2:0], 8'h00};
            r_pin_out <= bus.cmd_in[PAYLOAD_LEN-1];
            r_pin_oe  <= 1'b1;
            r_ack_out <= 1'b1;
            r_busy    <= 1'b1;
            r_cnt     <= 6'd47;
            r_state   <= SEND;
          end
        end
        SEND: begin
          if (r_cnt == 6'd0) begin
            r_pin_oe  <= 1'b0;
            r_pin_out <= 1'b1;
            r_cnt     <= 6'(TURN_CYCLES - 1);
            r_state   <= TURN;
          end else begin
            r_cnt <= r_cnt - 6'd1;
            if (r_cnt > 6'd8) begin
              r_pin_out <= r_shift[FRAME_LEN-2];
              r_shift   <= {r_shift[FRAME_LEN-3:0], 1'b0};
            end else begin
              r_pin_out <= w_tail[w_idx];
            end
          end
        end
        TURN: begin
          if (r_cnt == 6'd0) begin
            r_wait  <= '0;
            r_state <= WAIT_RESP;
          end else begin
            r_cnt <= r_cnt - 6'd1;
          end
        end
        WAIT_RESP: begin
          if (!bus.cmd_pin_in) begin
            r_shift  <= {r_shift[FRAME_LEN-3:0], 1'b0};
            r_rx_bad <= 1'b0;
            r_cnt    <= 6'd46;
            r_state  <= RECV;
          end else if (r_wait == WW'(WAIT_MAX - 1)) begin
            r_cmd_out      <= '0;
            r_resp_timeout <= 1'b1;
            r_strobe_out   <= 1'b1;
            r_state        <= DONE;
          end else begin
            r_wait <= r_wait + 1'b1;
          end
        end
        RECV: begin
          r_shift <= {r_shift[FRAME_LEN-3:0], bus.cmd_pin_in};
          if (r_cnt < 6'd8 && r_cnt != 6'd0 && bus.cmd_pin_in != w_crc[w_idx]) begin
            r_rx_bad <= 1'b1;
          end
          if (r_cnt == 6'd0) begin
            r_cmd_out    <= r_shift[FRAME_LEN-2:7];
            r_crc_error  <= r_rx_bad | ~bus.cmd_pin_in;
            r_strobe_out <= 1'b1;
            r_state      <= DONE;
          end else begin
            r_cnt <= r_cnt - 6'd1;
          end
        end
        DONE: begin
          if (bus.ack_in) begin
            r_strobe_out   <= 1'b0;
            r_crc_error    <= 1'b0;
            r_resp_timeout <= 1'b0;
            r_busy         <= 1'b0;
            r_state        <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.ack_out      = r_ack_out;
  assign bus.strobe_out   = r_strobe_out;
  assign bus.cmd_out      = r_cmd_out;
  assign bus.crc_error    = r_crc_error;
  assign bus.resp_timeout = r_resp_timeout;
  assign bus.busy         = r_busy;
  assign bus.cmd_pin_out  = r_pin_out;
  assign bus.cmd_pin_oe   = r_pin_oe;

endmodule

// File: tb/tb_sd_cmd_phy.sv
// Directed bench for sd_cmd_phy: table of full transactions plus hand sequences.
module tb_sd_cmd_phy;

  localparam int WAIT_MAX    = 64;
  localparam int TURN_CYCLES = 2;

  typedef struct {
    logic [39:0] cmd;
    logic [47:0] frame;
    bit          resp_en;
    logic [47:0] resp;
    logic [39:0] exp_out;
    bit          exp_crc;
    bit          exp_to;
    bit          ack_now;
  } vec_t;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   n_pass  = 0;
  int   n_total = 0;
  vec_t vecs[6];

  sd_cmd_phy_if bus ();

  sd_cmd_phy #(.WAIT_MAX(WAIT_MAX), .TURN_CYCLES(TURN_CYCLES)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string name, input logic [47:0] act, input logic [47:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Full transaction: send, optional card response, status, ack.
  task automatic run_txn(input vec_t v, input bit hold);
    int          acks;
    int          oe_cyc;
    int          k;
    logic [47:0] got;
    bus.cmd_in    = v.cmd;
    bus.strobe_in = 1'b1;
    tick();
    chk("ack_pulse", bus.ack_out, 1);
    chk("busy_send", bus.busy, 1);
    acks = 0; oe_cyc = 0; got = '0; k = 0;
    while (bus.cmd_pin_oe === 1'b1 && k < 100) begin
      got = {got[46:0], bus.cmd_pin_out};
      oe_cyc++;
      acks += int'(bus.ack_out);
      k++;
      if (!hold) bus.strobe_in = 1'b0;
      tick();
    end
    chk("ack_count", acks, 1);
    chk("oe_cycles", oe_cyc, 48);
    chk("tx_frame", got, v.frame);
    chk("pin_idle_high", bus.cmd_pin_out, 1);
    k = 0;
    if (v.resp_en) begin
      repeat (5) tick();
      for (int i = 47; i >= 0; i--) begin
        bus.cmd_pin_in = v.resp[i];
        tick();
      end
      bus.cmd_pin_in = 1'b1;
      while (bus.strobe_out !== 1'b1 && k < 10) begin tick(); k++; end
      chk("resp_latency", k, 0);
    end else begin
      while (bus.strobe_out !== 1'b1 && k < 200) begin tick(); k++; end
      chk("timeout_cycles", k, TURN_CYCLES + WAIT_MAX);
    end
    chk("strobe_out", bus.strobe_out, 1);
    chk("cmd_out", bus.cmd_out, v.exp_out);
    chk("crc_error", bus.crc_error, v.exp_crc);
    chk("resp_timeout", bus.resp_timeout, v.exp_to);
    if (!v.ack_now) begin
      tick(); tick();
      chk("strobe_held", bus.strobe_out, 1);
      chk("cmd_out_held", bus.cmd_out, v.exp_out);
    end
    bus.ack_in = 1'b1;
    tick();
    bus.ack_in = 1'b0;
    chk("strobe_cleared", bus.strobe_out, 0);
    chk("status_cleared", {bus.crc_error, bus.resp_timeout}, 0);
    chk("busy_idle", bus.busy, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int acks;
    int busy_seen;
    vecs[0] = '{40'h48_0000_01AA, 48'h48_0000_01AA_87, 1'b1, 48'h08_0000_01AA_13, 40'h08_0000_01AA, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{40'h40_0000_0000, 48'h40_0000_0000_95, 1'b0, 48'h0,               40'h0,            1'b0, 1'b1, 1'b0};
    vecs[2] = '{40'h48_0000_01AA, 48'h48_0000_01AA_87, 1'b1, 48'h08_0000_01AA_15, 40'h08_0000_01AA, 1'b1, 1'b0, 1'b0};
    vecs[3] = '{40'h77_0000_0000, 48'h77_0000_0000_65, 1'b1, 48'h08_0000_01AA_13, 40'h08_0000_01AA, 1'b0, 1'b0, 1'b1};
    vecs[4] = '{40'h7A_0000_0000, 48'h7A_0000_0000_FD, 1'b1, 48'h08_0000_01AB_13, 40'h08_0000_01AB, 1'b1, 1'b0, 1'b0};
    vecs[5] = '{40'h69_4000_0000, 48'h69_4000_0000_77, 1'b1, 48'h08_0000_01AA_12, 40'h08_0000_01AA, 1'b1, 1'b0, 1'b1};

    bus.strobe_in  = 1'b0;
    bus.cmd_in     = '0;
    bus.ack_in     = 1'b0;
    bus.cmd_pin_in = 1'b1;
    tick(); tick();
    chk("rst_pin_out", bus.cmd_pin_out, 1);
    chk("rst_pin_oe", bus.cmd_pin_oe, 0);
    chk("rst_flags", {bus.ack_out, bus.strobe_out, bus.crc_error, bus.resp_timeout, bus.busy}, 0);
    chk("rst_cmd_out", bus.cmd_out, 0);
    reset = 1'b0;
    tick();

    for (int i = 0; i < 6; i++) run_txn(vecs[i], 1'b0);

    // Held strobe: no re-launch until strobe_in drops for a cycle.
    run_txn(vecs[0], 1'b1);
    acks = 0; busy_seen = 0;
    repeat (10) begin
      tick();
      acks += int'(bus.ack_out);
      busy_seen += int'(bus.busy);
    end
    chk("held_no_ack", acks, 0);
    chk("held_no_busy", busy_seen, 0);
    bus.strobe_in = 1'b0;
    tick();
    run_txn(vecs[3], 1'b0);

    // Async reset while bit 20 is on the pin.
    bus.cmd_in    = 40'h48_0000_01AA;
    bus.strobe_in = 1'b1;
    tick();
    bus.strobe_in = 1'b0;
    repeat (27) tick();
    chk("pre_rst_bit20", bus.cmd_pin_out, vecs[0].frame[20]);
    chk("pre_rst_oe", bus.cmd_pin_oe, 1);
    #2 reset = 1'b1;
    #1;
    chk("midrst_oe", bus.cmd_pin_oe, 0);
    chk("midrst_busy", bus.busy, 0);
    chk("midrst_pin", bus.cmd_pin_out, 1);
    chk("midrst_status", {bus.ack_out, bus.strobe_out}, 0);
    tick(); tick();
    reset = 1'b0;
    tick();
    run_txn(vecs[0], 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
